// File: rtl/vec_switch.sv
// rtl/vec_switch.sv - N-core vector mailbox switch, one single-entry slot per (source, destination) pair
module vec_switch #(
   parameter int SWITCH_CORE_SIZE      = 4,
   parameter int SWITCH_WIDTH          = 16,
   parameter int SWITCH_CORE_ADDR_SIZE = $clog2(SWITCH_CORE_SIZE)
) (
   input  logic                                                clock,
   input  logic                                                reset_n,
   input  logic [SWITCH_CORE_SIZE-1:0]                         switch_send_ready,
   input  logic [SWITCH_CORE_SIZE*SWITCH_CORE_ADDR_SIZE-1:0]   switch_send_core_idx,
   input  logic [SWITCH_CORE_SIZE*SWITCH_WIDTH*32-1:0]         switch_send_data,
   output logic [SWITCH_CORE_SIZE-1:0]                         switch_send_ok,
   input  logic [SWITCH_CORE_SIZE-1:0]                         switch_recv_request,
   input  logic [SWITCH_CORE_SIZE*SWITCH_CORE_ADDR_SIZE-1:0]   switch_recv_core_idx,
   output logic [SWITCH_CORE_SIZE-1:0]                         switch_recv_ready,
   output logic [SWITCH_CORE_SIZE*SWITCH_WIDTH*32-1:0]         switch_recv_data,
   output logic [SWITCH_CORE_SIZE*SWITCH_CORE_SIZE-1:0]        slot_full
);

   localparam int N  = SWITCH_CORE_SIZE;
   localparam int A  = SWITCH_CORE_ADDR_SIZE;
   localparam int VW = SWITCH_WIDTH * 32;

   // send_free[s][d]: core s addresses d and slot[s][d] is empty.
   // recv_avail[d][s]: core d addresses s and slot[s][d] is full.
   // An out-of-range idx matches no d, so it can never be accepted.
   logic [N-1:0]  send_free  [N];
   logic [N-1:0]  recv_avail [N];
   logic [N-1:0]  send_acc;
   logic [N-1:0]  recv_acc;
   logic [VW-1:0] slot_data  [N][N];

   // Accept decode; a slot is either empty (only a send can hit it) or full
   // (only a recv can hit it), so same-slot races resolve without arbitration.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         send_free[i]  = '0;
         recv_avail[i] = '0;
      end
      send_acc = '0;
      recv_acc = '0;
      for (int s = 0; s < N; s++) begin
         for (int d = 0; d < N; d++) begin
            send_free[s][d]  = (switch_send_core_idx[s*A +: A] == A'(d)) && !slot_full[s*N+d];
            recv_avail[d][s] = (switch_recv_core_idx[d*A +: A] == A'(s)) && slot_full[s*N+d];
         end
      end
      for (int i = 0; i < N; i++) begin
         send_acc[i] = switch_send_ready[i]   && !switch_send_ok[i]    && (|send_free[i]);
         recv_acc[i] = switch_recv_request[i] && !switch_recv_ready[i] && (|recv_avail[i]);
      end
   end

   // Mailbox slots: a send fills an empty slot, a recv drains a full one.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         slot_full <= '0;
         for (int s = 0; s < N; s++) begin
            for (int d = 0; d < N; d++) begin
               slot_data[s][d] <= '0;
            end
         end
      end else begin
         for (int s = 0; s < N; s++) begin
            for (int d = 0; d < N; d++) begin
               if (send_acc[s] && send_free[s][d]) begin
                  slot_full[s*N+d] <= 1'b1;
                  slot_data[s][d]  <= switch_send_data[s*VW +: VW];
               end else if (recv_acc[d] && recv_avail[d][s]) begin
                  slot_full[s*N+d] <= 1'b0;
               end
            end
         end
      end
   end

   // Registered handshake pulses and delivered vectors; recv data holds between pulses.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         switch_send_ok    <= '0;
         switch_recv_ready <= '0;
         switch_recv_data  <= '0;
      end else begin
         switch_send_ok    <= send_acc;
         switch_recv_ready <= recv_acc;
         for (int d = 0; d < N; d++) begin
            for (int s = 0; s < N; s++) begin
               if (recv_acc[d] && recv_avail[d][s]) begin
                  switch_recv_data[d*VW +: VW] <= slot_data[s][d];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_vec_switch.sv
// tb/tb_vec_switch.sv - table-driven and directed sequence bench for vec_switch
module tb_vec_switch;

   localparam int N  = 4;
   localparam int VW = 512;

   logic            clock;
   logic            reset_n;
   logic [3:0]      sr;
   logic [7:0]      sidx;
   logic [2047:0]   sdata;
   logic [3:0]      ok;
   logic [3:0]      rq;
   logic [7:0]      ridx;
   logic [3:0]      rdy;
   logic [2047:0]   rdata;
   logic [15:0]     full;

   int n_tests = 0;
   int n_fail  = 0;

   vec_switch dut (
      .clock                (clock),
      .reset_n              (reset_n),
      .switch_send_ready    (sr),
      .switch_send_core_idx (sidx),
      .switch_send_data     (sdata),
      .switch_send_ok       (ok),
      .switch_recv_request  (rq),
      .switch_recv_core_idx (ridx),
      .switch_recv_ready    (rdy),
      .switch_recv_data     (rdata),
      .slot_full            (full)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [3:0]  sr;
      logic [7:0]  sidx;
      logic [3:0]  rq;
      logic [7:0]  ridx;
      logic [7:0]  tag;
      logic [3:0]  e_ok;
      logic [3:0]  e_rdy;
      logic [15:0] e_full;
      logic [7:0]  dtag;
   } vec_t;

   vec_t tbl [14];

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [511:0] make_vec(input int s, input logic [7:0] tag);
      logic [511:0] v;
      for (int j = 0; j < 16; j++) v[32*j +: 32] = {tag, 8'(s), 8'(j), 8'hA5};
      return v;
   endfunction

   task automatic set_data(input logic [7:0] tag);
      for (int s = 0; s < N; s++) sdata[s*VW +: VW] = make_vec(s, tag);
   endtask

   logic [31:0]  fl [16];
   logic [511:0] fvec;
   int           hits;

   initial begin
      fl = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
             32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
             32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
      for (int j = 0; j < 16; j++) fvec[32*j +: 32] = fl[j];

      //           sr       sidx   rq       ridx   tag    e_ok     e_rdy    e_full    dtag
      tbl[0]  = '{4'b1111, 8'h61, 4'b0000, 8'h00, 8'h11, 4'b1111, 4'b0000, 16'h2412, 8'h00};
      tbl[1]  = '{4'b0000, 8'h00, 4'b0111, 8'h21, 8'h11, 4'b0000, 4'b0111, 16'h2000, 8'h11};
      tbl[2]  = '{4'b0000, 8'h00, 4'b0010, 8'h0C, 8'h11, 4'b0000, 4'b0000, 16'h2000, 8'h00};
      tbl[3]  = '{4'b0000, 8'h00, 4'b0010, 8'h0C, 8'h11, 4'b0000, 4'b0010, 16'h0000, 8'h11};
      tbl[4]  = '{4'b0000, 8'h00, 4'b0000, 8'h00, 8'h11, 4'b0000, 4'b0000, 16'h0000, 8'h00};
      tbl[5]  = '{4'b0001, 8'h01, 4'b0000, 8'h00, 8'h22, 4'b0001, 4'b0000, 16'h0002, 8'h00};
      tbl[6]  = '{4'b0000, 8'h00, 4'b0000, 8'h00, 8'h22, 4'b0000, 4'b0000, 16'h0002, 8'h00};
      tbl[7]  = '{4'b0001, 8'h01, 4'b0010, 8'h00, 8'h33, 4'b0000, 4'b0010, 16'h0000, 8'h22};
      tbl[8]  = '{4'b0001, 8'h01, 4'b0010, 8'h00, 8'h33, 4'b0001, 4'b0000, 16'h0002, 8'h00};
      tbl[9]  = '{4'b0000, 8'h00, 4'b0010, 8'h00, 8'h33, 4'b0000, 4'b0010, 16'h0000, 8'h33};
      tbl[10] = '{4'b0000, 8'h00, 4'b0000, 8'h00, 8'h33, 4'b0000, 4'b0000, 16'h0000, 8'h00};
      tbl[11] = '{4'b0001, 8'h01, 4'b0010, 8'h00, 8'h44, 4'b0001, 4'b0000, 16'h0002, 8'h00};
      tbl[12] = '{4'b0001, 8'h01, 4'b0010, 8'h00, 8'h44, 4'b0000, 4'b0010, 16'h0000, 8'h44};
      tbl[13] = '{4'b0000, 8'h00, 4'b0000, 8'h00, 8'h44, 4'b0000, 4'b0000, 16'h0000, 8'h00};

      reset_n = 1'b0;
      sr = '0; sidx = '0; rq = '0; ridx = '0; sdata = '0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_ok", 512'(ok), 512'(0));
      chk("rst_rdy", 512'(rdy), 512'(0));
      chk("rst_full", 512'(full), 512'(0));
      chk("rst_rdata", 512'(|rdata), 512'(0));
      reset_n = 1'b1;
      tick();

      // basic transfer 0 -> 2 with float lanes
      sdata[0 +: VW] = fvec;
      sr = 4'b0001; sidx = 8'h02;
      tick();
      chk("basic_ok", 512'(ok), 512'(4'b0001));
      chk("basic_full", 512'(full), 512'(16'h0004));
      sr = '0; rq = 4'b0100; ridx = 8'h00;
      tick();
      chk("basic_rdy", 512'(rdy), 512'(4'b0100));
      chk("basic_data", rdata[2*VW +: VW], fvec);
      chk("basic_empty", 512'(full), 512'(0));
      rq = '0;
      tick();
      chk("basic_rdy_pulse", 512'(rdy), 512'(0));
      chk("basic_hold", rdata[2*VW +: VW], fvec);

      // back-pressure 1 -> 3, A then B
      sdata[1*VW +: VW] = make_vec(1, 8'hA1);
      sr = 4'b0010; sidx = 8'h0C;
      tick();
      chk("bp_ok_a", 512'(ok), 512'(4'b0010));
      sdata[1*VW +: VW] = make_vec(1, 8'hB2);
      hits = 0;
      repeat (20) begin
         tick();
         if (ok[1]) hits++;
      end
      chk("bp_stall", 512'(hits), 512'(0));
      chk("bp_full", 512'(full), 512'(16'h0080));
      rq = 4'b1000; ridx = 8'h40;
      tick();
      chk("bp_rdy_a", 512'(rdy), 512'(4'b1000));
      chk("bp_data_a", rdata[3*VW +: VW], make_vec(1, 8'hA1));
      chk("bp_b_wait", 512'(ok), 512'(0));
      rq = '0;
      tick();
      chk("bp_ok_b", 512'(ok), 512'(4'b0010));
      chk("bp_full_b", 512'(full), 512'(16'h0080));
      sr = '0; rq = 4'b1000;
      tick();
      chk("bp_rdy_b", 512'(rdy), 512'(4'b1000));
      chk("bp_data_b", rdata[3*VW +: VW], make_vec(1, 8'hB2));
      rq = '0;
      tick();

      // recv before send: core 3 waits on core 0
      rq = 4'b1000; ridx = 8'h00;
      hits = 0;
      repeat (10) begin
         tick();
         if (rdy[3]) hits++;
      end
      chk("rbs_no_rdy", 512'(hits), 512'(0));
      sdata[0 +: VW] = make_vec(0, 8'hC3);
      sr = 4'b0001; sidx = 8'h03;
      tick();
      chk("rbs_ok", 512'(ok), 512'(4'b0001));
      chk("rbs_rdy_early", 512'(rdy), 512'(0));
      chk("rbs_full", 512'(full), 512'(16'h0008));
      sr = '0;
      tick();
      chk("rbs_rdy", 512'(rdy), 512'(4'b1000));
      chk("rbs_data", rdata[3*VW +: VW], make_vec(0, 8'hC3));
      rq = '0;
      tick();

      // concurrency and same-slot race trace
      for (int i = 0; i < 14; i++) begin
         sr = tbl[i].sr; sidx = tbl[i].sidx; rq = tbl[i].rq; ridx = tbl[i].ridx;
         set_data(tbl[i].tag);
         tick();
         chk($sformatf("tbl%0d_ok", i), 512'(ok), 512'(tbl[i].e_ok));
         chk($sformatf("tbl%0d_rdy", i), 512'(rdy), 512'(tbl[i].e_rdy));
         chk($sformatf("tbl%0d_full", i), 512'(full), 512'(tbl[i].e_full));
         for (int d = 0; d < N; d++) begin
            if (tbl[i].e_rdy[d])
               chk($sformatf("tbl%0d_data%0d", i, d), rdata[d*VW +: VW],
                   make_vec(int'(tbl[i].ridx[2*d +: 2]), tbl[i].dtag));
         end
      end

      // reset mid-operation with recv_ready[0] pending
      sdata[2*VW +: VW] = make_vec(2, 8'hD4);
      sr = 4'b0100; sidx = 8'h00;
      tick();
      chk("mr_ok", 512'(ok), 512'(4'b0100));
      chk("mr_full", 512'(full), 512'(16'h0100));
      sr = '0; rq = 4'b0001; ridx = 8'h02;
      tick();
      chk("mr_rdy", 512'(rdy), 512'(4'b0001));
      reset_n = 1'b0;
      #1;
      chk("mr_rst_rdy", 512'(rdy), 512'(0));
      chk("mr_rst_ok", 512'(ok), 512'(0));
      chk("mr_rst_full", 512'(full), 512'(0));
      chk("mr_rst_rdata", 512'(|rdata), 512'(0));
      tick();
      tick();
      reset_n = 1'b1;
      hits = 0;
      repeat (5) begin
         tick();
         if (rdy[0]) hits++;
      end
      chk("mr_no_rdy", 512'(hits), 512'(0));
      sdata[2*VW +: VW] = make_vec(2, 8'hE5);
      sr = 4'b0100;
      tick();
      chk("mr_ok2", 512'(ok), 512'(4'b0100));
      sr = '0;
      tick();
      chk("mr_rdy2", 512'(rdy), 512'(4'b0001));
      chk("mr_data2", rdata[0 +: VW], make_vec(2, 8'hE5));
      rq = '0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vec_switch.md
# vec_switch

Inter-core data switch for the vector cluster: downstream of every `VecCore` send port and upstream of every `VecCore` receive port. Holds one `SWITCH_WIDTH`-lane vector per (source, destination) core pair in a single-entry mailbox slot. Senders address a destination core; receivers address a source core. Ready/ok handshakes are registered on both sides.

## Interface
- `SWITCH_CORE_SIZE`, 4: number of attached cores (N).
- `SWITCH_WIDTH`, 16: lanes per vector (W); each lane is a 32-bit IEEE-754 single bit pattern.
- `SWITCH_CORE_ADDR_SIZE`, `$clog2(SWITCH_CORE_SIZE)`: core index width (A). Auto-derived; do not override.

Ports (per-core signals are flattened, core i occupies slice i):
- `clock`  in  1  single clock, all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `switch_send_ready`  in  N  core i requests a send.
- `switch_send_core_idx`  in  N*A  destination core of core i's send.
- `switch_send_data`  in  N*W*32  vector from core i, lane j at bits [32j+31:32j] of slice i.
- `switch_send_ok`  out  N  one-cycle pulse: core i's send was accepted.
- `switch_recv_request`  in  N  core i requests a receive.
- `switch_recv_core_idx`  in  N*A  source core that core i receives from.
- `switch_recv_ready`  out  N  one-cycle pulse: `switch_recv_data` slice i is valid.
- `switch_recv_data`  out  N*W*32  vector delivered to core i.
- `slot_full`  out  N*N  debug: bit (s*N+d) is set when slot[s][d] holds data.

## Operation
- State: slot_full[s][d] and slot_data[s][d] (W*32 bits each), plus registered send_ok[i], recv_ready[i] and recv_data[i].
- Send accept for core s in cycle T requires all of: send_ready[s]=1, send_ok[s]=0 (guard cycle), idx d<N, and slot_full[s][d]=0 at the start of T.
  - On accept, slot_data[s][d]←send_data[s] and slot_full[s][d]←1 at edge T.
  - send_ok[s]=1 during T+1 only.
- Recv accept for core d in cycle T requires all of: recv_request[d]=1, recv_ready[d]=0, idx s<N, and slot_full[s][d]=1 at the start of T.
  - On accept, recv_data[d]←slot_data[s][d] and slot_full[s][d]←0 at edge T.
  - recv_ready[d]=1 during T+1 only.
- Each core holds its request level with stable idx and data until it sees ok or ready. In the ok/ready cycle, that core's request is ignored, so one request cannot be accepted twice. A fresh request can be accepted at T+2 at the earliest.
- Different (s,d) slots are fully independent: any number of sends and receives can be accepted in one cycle.
- A core can send and receive in the same cycle.
- Self-send (d==s) is legal and uses slot[s][s].
- Same slot, same cycle:
  - Empty slot, send and recv both pending: send is accepted, recv is not (no bypass). Recv is accepted the next cycle.
  - Full slot, send and recv both pending: recv is accepted, send stalls. Send is accepted the next cycle.
- An out-of-range idx (≥N, possible when N is not a power of 2) is never accepted. ok/ready stays 0 and no state changes.
- recv_data[d] holds its last delivered value between pulses.

## Timing
- Reset (reset_n=0, asynchronous) forces:
  - all slot_full=0;
  - switch_send_ok=0, switch_recv_ready=0;
  - switch_recv_data=0.
  - slot_data is cleared to 0.
- Outputs are valid from the first edge after reset_n rises.
- Reset mid-transfer drops all stored vectors. A pending ok/ready pulse is cancelled immediately (asynchronously).
- Latency, empty slot: send request at T, send_ok at T+1, slot_full visible at T+1.
- Latency, recv waiting: matching recv request accepted at T+1, recv_ready/data at T+2.
- Minimum end-to-end latency is 2 cycles. Per slot, sustained throughput is one vector per 2 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Basic transfer, N=4 W=16: core 0 sends lanes j=1.0+j (0x3F800000…) to core 2 at T0.
  - send_ok[0] pulses at T0+1.
  - Core 2 then requests from 0: recv_ready[2] pulses one cycle later and data matches bit-exact.
  - slot_full bit 2 returns to 0.
- Back-pressure: core 1 sends A then B to core 3 with no receive.
  - A gets ok; B waits with send_ok[1]=0 for 20 cycles.
  - Core 3 receives A. B is accepted the cycle after the slot empties, then core 3 receives B. Order is A, B.
- Recv before send: core 3 requests from core 0 for 10 cycles with no ready. Core 0 then sends; recv_ready[3] fires 2 cycles after the send request.
- Concurrency: in one cycle, cores 0→1, 1→0, 2→2 (self-send) and 3→1.
  - All four send_ok pulse together.
  - Core 1 receives from 0 and then from 3 with correct data.
  - Core 0 receives from 1; core 2 receives from 2.
- Same-slot race: with slot[0][1] full, core 1 receives and core 0 sends in the same cycle.
  - recv_ready[1] pulses, then send_ok[0] pulses one cycle later.
  - Repeat with the slot empty: send accepted first, recv the next cycle.
- Reset mid-operation: fill slot[2][0] and assert reset_n=0 while recv_ready[0] is pending.
  - Outputs go to 0 immediately and slot_full=0.
  - After release, core 0 requesting from 2 gets no ready until a new send.
